stack_calc_core: RTL and testbench

STACK_CALC_CORE -- requirements
Module: stack_calc_core

---
 rtl/stack_calc_pkg.sv | 31 +++
 rtl/stack_calc_if.sv | 36 +++
 rtl/stack_ram.sv | 28 ++
 rtl/stack_calc_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_stack_calc_core.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/stack_calc_pkg.sv
// Shared opcode and FSM state encodings for the stack calculator core.
package stack_calc_pkg;

  localparam int OP_W = 3;
  localparam int ST_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_PUSH    = 3'd0,
    OP_POP     = 3'd1,
    OP_ADD     = 3'd2,
    OP_SUB     = 3'd3,
    OP_TOP     = 3'd4,
    OP_CLR     = 3'd5,
    OP_BRW_DEC = 3'd6,
    OP_BRW_INC = 3'd7
  } op_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic logic op_is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/stack_calc_if.sv
// Command/status bundle between a host and stack_calc_core.
interface stack_calc_if
  import stack_calc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
);
  localparam int AW = $clog2(DEPTH);

  logic              op_valid;
  logic [OP_W-1:0]   op_code;
  logic [DATA_W-1:0] op_data;
  logic              op_ready;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [AW:0]       count;
  logic [AW-1:0]     brw_addr;
  logic              empty;
  logic              full;
  logic              err_uflow;
  logic              err_oflow;
  logic              err_arith;

  modport master (
    output op_valid, op_code, op_data,
    input  op_ready, done, result, count, brw_addr, empty, full,
           err_uflow, err_oflow, err_arith
  );

  modport slave (
    input  op_valid, op_code, op_data,
    output op_ready, done, result, count, brw_addr, empty, full,
           err_uflow, err_oflow, err_arith
  );

endinterface

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous read with one-cycle latency, no reset.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // one access per cycle: either write or registered read
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_calc_core.sv
// Stack calculator core: command FSM around a single-port stack RAM.
// Optional build macro STACK_CALC_SAT_EN makes ADD/SUB saturate instead of wrap.
module stack_calc_core
  import stack_calc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input logic         clk,
  input logic         rst_n,
  stack_calc_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]       CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]       CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]       CNT_TWO   = (AW+1)'(2);
  localparam logic [AW-1:0]     ADDR_ZERO = AW'(0);
  localparam logic [AW-1:0]     ADDR_ONE  = AW'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  op_e               w_op;
  logic [AW:0]       r_count;
  logic [AW-1:0]     r_brw;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_wdata;
  logic [AW-1:0]     r_waddr;
  logic              r_done;
  logic              r_ready;
  logic              r_uflow;
  logic              r_oflow;
  logic              r_arith;

  logic              w_accept;
  logic              w_empty;
  logic              w_full;
  logic              w_lt2;
  logic [AW:0]       w_cnt_m1;
  logic [AW:0]       w_cnt_m2;
  logic [AW-1:0]     w_top_addr;
  logic [AW-1:0]     w_nxt_addr;
  logic [AW-1:0]     w_brw_next;
  logic [AW-1:0]     w_addr;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_exec_res;
  logic              w_exec_flag;

  assign w_op       = op_e'(bus.op_code);
  assign w_accept   = bus.op_valid && (r_state == ST_IDLE);
  assign w_empty    = (r_count == CNT_ZERO);
  assign w_full     = (r_count == DEPTH_C);
  assign w_lt2      = (r_count < CNT_TWO);
  assign w_cnt_m1   = r_count - CNT_ONE;
  assign w_cnt_m2   = r_count - CNT_TWO;
  assign w_top_addr = w_cnt_m1[AW-1:0];
  assign w_nxt_addr = w_cnt_m2[AW-1:0];

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  // browse pointer target, saturating at the bottom and at the current top
  always_comb begin
    w_brw_next = r_brw;
    if (w_empty) begin
      w_brw_next = r_brw;
    end else if (w_op == OP_BRW_DEC) begin
      w_brw_next = (r_brw == ADDR_ZERO) ? ADDR_ZERO : (r_brw - ADDR_ONE);
    end else if (r_brw >= w_top_addr) begin
      w_brw_next = w_top_addr;
    end else begin
      w_brw_next = r_brw + ADDR_ONE;
    end
  end

  // ALU: one extra bit catches ADD carry-out and SUB borrow
  always_comb begin
    w_sum  = {1'b0, r_b} + {1'b0, r_a};
    w_diff = {1'b0, r_b} - {1'b0, r_a};
    w_exec_flag = (r_op == OP_SUB) ? w_diff[DATA_W] : w_sum[DATA_W];
`ifdef STACK_CALC_SAT_EN
    if (w_exec_flag) begin
      w_exec_res = (r_op == OP_SUB) ? DATA_ZERO : {DATA_W{1'b1}};
    end else begin
      w_exec_res = (r_op == OP_SUB) ? w_diff[DATA_W-1:0] : w_sum[DATA_W-1:0];
    end
`else
    w_exec_res = (r_op == OP_SUB) ? w_diff[DATA_W-1:0] : w_sum[DATA_W-1:0];
`endif
  end

  // RAM port: reads are launched a cycle early so data lands in RD_A/RD_B
  always_comb begin
    w_addr = w_top_addr;
    w_we   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (w_op)
          OP_POP:                 w_addr = w_nxt_addr;
          OP_BRW_DEC, OP_BRW_INC: w_addr = w_brw_next;
          default:                w_addr = w_top_addr;
        endcase
      end
      ST_RD_A: w_addr = w_nxt_addr;
      ST_WR: begin
        w_addr = r_waddr;
        w_we   = rst_n;
      end
      default: w_addr = w_top_addr;
    endcase
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_PUSH:           w_next = w_full  ? ST_DONE : ST_WR;
            OP_POP, OP_TOP:    w_next = w_empty ? ST_DONE : ST_RD_A;
            OP_ADD, OP_SUB:    w_next = w_lt2   ? ST_DONE : ST_RD_A;
            OP_CLR:            w_next = ST_DONE;
            default:           w_next = ST_RD_A;
          endcase
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RD_A: w_next = op_is_arith(r_op) ? ST_RD_B : ST_DONE;
      ST_RD_B: w_next = ST_EXEC;
      ST_EXEC: w_next = ST_WR;
      ST_WR:   w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // datapath, stack bookkeeping and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= OP_PUSH;
      r_count  <= CNT_ZERO;
      r_brw    <= ADDR_ZERO;
      r_result <= DATA_ZERO;
      r_a      <= DATA_ZERO;
      r_b      <= DATA_ZERO;
      r_wdata  <= DATA_ZERO;
      r_waddr  <= ADDR_ZERO;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
      r_uflow  <= 1'b0;
      r_oflow  <= 1'b0;
      r_arith  <= 1'b0;
    end else begin
      r_done  <= (w_next == ST_DONE);
      r_ready <= (w_next == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= w_op;
            case (w_op)
              OP_PUSH: begin
                r_oflow <= r_oflow | w_full;
                r_wdata <= bus.op_data;
                r_waddr <= r_count[AW-1:0];
              end
              OP_POP, OP_TOP: r_uflow <= r_uflow | w_empty;
              OP_ADD, OP_SUB: r_uflow <= r_uflow | w_lt2;
              OP_CLR: begin
                r_count  <= CNT_ZERO;
                r_brw    <= ADDR_ZERO;
                r_result <= DATA_ZERO;
                r_uflow  <= 1'b0;
                r_oflow  <= 1'b0;
                r_arith  <= 1'b0;
              end
              default: r_brw <= w_brw_next;
            endcase
          end else begin
            r_op <= r_op;
          end
        end
        ST_RD_A: begin
          case (r_op)
            OP_POP: begin
              r_count  <= w_cnt_m1;
              r_brw    <= (r_count == CNT_ONE) ? ADDR_ZERO : w_nxt_addr;
              r_result <= (r_count == CNT_ONE) ? DATA_ZERO : w_rdata;
            end
            OP_TOP:         r_result <= w_rdata;
            OP_ADD, OP_SUB: r_a      <= w_rdata;
            default:        r_result <= w_empty ? DATA_ZERO : w_rdata;
          endcase
        end
        ST_RD_B: r_b <= w_rdata;
        ST_EXEC: begin
          r_wdata <= w_exec_res;
          r_waddr <= w_nxt_addr;
          r_arith <= r_arith | w_exec_flag;
        end
        ST_WR: begin
          r_result <= r_wdata;
          if (r_op == OP_PUSH) begin
            r_count <= r_count + CNT_ONE;
            r_brw   <= r_count[AW-1:0];
          end else begin
            r_count <= w_cnt_m1;
            r_brw   <= w_nxt_addr;
          end
        end
        default: r_op <= r_op;
      endcase
    end
  end

  assign bus.op_ready  = r_ready;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.count     = r_count;
  assign bus.brw_addr  = r_brw;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.err_uflow = r_uflow;
  assign bus.err_oflow = r_oflow;
  assign bus.err_arith = r_arith;

endmodule

// File: tb/tb_stack_calc_core.sv
// Self-checking bench for stack_calc_core: directed scenarios plus random commands vs a queue model.
module tb_stack_calc_core;
  import stack_calc_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_calc_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  stack_calc_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_stk[$];
  int         m_brw;
  logic [7:0] m_res;
  bit         m_uf, m_of, m_ar;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_brw = 0; m_res = 8'h00;
    m_uf = 1'b0; m_of = 1'b0; m_ar = 1'b0;
  endtask

  // stack semantics from the rules, plus expected accept-to-done latency
  task automatic model_op(input logic [2:0] op, input logic [7:0] d, output int lat);
    int sz, a, b, r;
    bit flag;
    sz = m_stk.size();
    case (op)
      3'd0: if (sz == DEPTH) begin m_of = 1'b1; lat = 1; end
            else begin m_stk.push_back(d); m_brw = sz; m_res = d; lat = 2; end
      3'd1: if (sz == 0) begin m_uf = 1'b1; lat = 1; end
            else begin
              void'(m_stk.pop_back());
              m_res = (sz > 1) ? m_stk[sz-2] : 8'h00;
              m_brw = (sz > 1) ? sz - 2 : 0;
              lat = 2;
            end
      3'd2, 3'd3: if (sz < 2) begin m_uf = 1'b1; lat = 1; end
            else begin
              a = int'(m_stk.pop_back());
              b = int'(m_stk.pop_back());
              if (op == 3'd2) begin r = b + a; flag = (r > 255); end
              else begin r = b - a; flag = (a > b); end
              r = r & 255;
`ifdef STACK_CALC_SAT_EN
              if (flag) r = (op == 3'd2) ? 255 : 0;
`endif
              m_stk.push_back(8'(r));
              m_res = 8'(r); m_brw = sz - 2; m_ar = m_ar | flag; lat = 5;
            end
      3'd4: if (sz == 0) begin m_uf = 1'b1; lat = 1; end
            else begin m_res = m_stk[sz-1]; lat = 2; end
      3'd5: begin model_reset(); lat = 1; end
      default: begin
        lat = 2;
        if (sz == 0) m_res = 8'h00;
        else begin
          if (op == 3'd6) m_brw = (m_brw == 0) ? 0 : m_brw - 1;
          else m_brw = (m_brw >= sz - 1) ? sz - 1 : m_brw + 1;
          m_res = m_stk[m_brw];
        end
      end
    endcase
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_res"},   32'(bus.result),    32'(m_res));
    check_val({tag, "_cnt"},   32'(bus.count),     32'(m_stk.size()));
    check_val({tag, "_brw"},   32'(bus.brw_addr),  32'(m_brw));
    check_val({tag, "_empty"}, 32'(bus.empty),     32'(m_stk.size() == 0));
    check_val({tag, "_full"},  32'(bus.full),      32'(m_stk.size() == DEPTH));
    check_val({tag, "_uf"},    32'(bus.err_uflow), 32'(m_uf));
    check_val({tag, "_of"},    32'(bus.err_oflow), 32'(m_of));
    check_val({tag, "_ar"},    32'(bus.err_arith), 32'(m_ar));
  endtask

  // issue one command, spray ignored requests while busy, check timing and state
  task automatic run_op(input logic [2:0] op, input logic [7:0] d, input string tag);
    int lat, seen;
    for (int i = 0; i < 20 && bus.op_ready !== 1'b1; i++) @(negedge clk);
    check_val({tag, "_rdy"}, 32'(bus.op_ready), 32'd1);
    bus.op_valid = 1'b1; bus.op_code = op; bus.op_data = d;
    model_op(op, d, lat);
    seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin seen = i; break; end
      bus.op_valid = 1'($urandom_range(0, 1));
      bus.op_code  = 3'($urandom_range(0, 7));
      bus.op_data  = 8'($urandom);
    end
    bus.op_valid = 1'b0;
    check_val({tag, "_lat"}, 32'(seen), 32'(lat));
    check_status(tag);
    @(negedge clk);
    check_val({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int r;
    logic [7:0] sub_exp;
    bit saw_done;
    bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.op_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_rdy", 32'(bus.op_ready), 32'd1);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_status("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 8'h05, "a_push"); run_op(3'd0, 8'h03, "a_push");
    run_op(3'd2, 8'h00, "a_add");
    check_val("add_result", 32'(bus.result), 32'h08);
    check_val("add_count", 32'(bus.count), 32'd1);

`ifdef STACK_CALC_SAT_EN
    sub_exp = 8'h00;
`else
    sub_exp = 8'hFB;
`endif
    run_op(3'd5, 8'h00, "s_clr"); run_op(3'd0, 8'h02, "s_push"); run_op(3'd0, 8'h07, "s_push");
    run_op(3'd3, 8'h00, "s_sub");
    check_val("sub_result", 32'(bus.result), 32'(sub_exp));
    check_val("sub_arith", 32'(bus.err_arith), 32'd1);

    run_op(3'd5, 8'h00, "f_clr");
    for (int i = 0; i < 4; i++) run_op(3'd0, 8'(8'h40 + i), "f_push");
    check_val("full_after4", 32'(bus.full), 32'd1);
    run_op(3'd0, 8'h99, "f_over");
    check_val("oflow_flag", 32'(bus.err_oflow), 32'd1);
    check_val("oflow_count", 32'(bus.count), 32'd4);

    run_op(3'd5, 8'h00, "u_clr"); run_op(3'd1, 8'h00, "u_pop");
    check_val("uflow_flag", 32'(bus.err_uflow), 32'd1);
    check_val("uflow_res", 32'(bus.result), 32'h00);
    run_op(3'd5, 8'h00, "u_clr2");
    check_val("uflow_clr", 32'(bus.err_uflow), 32'd0);

    run_op(3'd0, 8'h11, "b_push"); run_op(3'd0, 8'h22, "b_push"); run_op(3'd0, 8'h33, "b_push");
    run_op(3'd6, 8'h00, "b_dec"); check_val("brw_dec1", 32'(bus.result), 32'h22);
    run_op(3'd6, 8'h00, "b_dec"); check_val("brw_dec2", 32'(bus.result), 32'h11);
    run_op(3'd6, 8'h00, "b_dec"); check_val("brw_dec3", 32'(bus.result), 32'h11);
    run_op(3'd7, 8'h00, "b_inc"); check_val("brw_inc", 32'(bus.result), 32'h22);

    // abort an ADD while its second operand read is in flight
    run_op(3'd5, 8'h00, "r_clr"); run_op(3'd0, 8'h44, "r_push"); run_op(3'd0, 8'h55, "r_push");
    bus.op_valid = 1'b1; bus.op_code = 3'd2;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check_val("abort_rdy", 32'(bus.op_ready), 32'd1);
    check_val("abort_done", 32'(bus.done), 32'd0);
    check_status("abort");
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin @(negedge clk); saw_done = saw_done | (bus.done === 1'b1); end
    check_val("abort_nodone", 32'(saw_done), 32'd0);
    check_val("abort_mem", 32'(u_dut.u_ram.r_mem[0]), 32'h44);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if      (r < 35) run_op(3'd0, 8'($urandom), "rnd_push");
      else if (r < 50) run_op(3'd1, 8'($urandom), "rnd_pop");
      else if (r < 60) run_op(3'd2, 8'($urandom), "rnd_add");
      else if (r < 70) run_op(3'd3, 8'($urandom), "rnd_sub");
      else if (r < 77) run_op(3'd4, 8'($urandom), "rnd_top");
      else if (r < 80) run_op(3'd5, 8'($urandom), "rnd_clr");
      else if (r < 90) run_op(3'd6, 8'($urandom), "rnd_dec");
      else             run_op(3'd7, 8'($urandom), "rnd_inc");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
